// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between host logic and the PS/2 transmitter
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       rx_inhibit;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_start, tx_data,
    input  busy, rx_inhibit, tx_done, tx_err
  );

  modport slave (
    input  tx_start, tx_data,
    output busy, rx_inhibit, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter for one command byte
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clock,
  input  logic         resetn,
  ps2_host_tx_if.slave host,
  input  logic         ps2c_in,
  input  logic         ps2d_in,
  output logic         ps2c_oe,
  output logic         ps2d_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PAR, S_ACK, S_WAIT_IDLE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_filt, c_prev;
  logic [FW-1:0] flt_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    sh;
  logic [3:0]    edge_cnt;
  logic          d_drive;
  logic          fall, done_now, busy, accept, timeout, inh_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_s1    <= 1'b1;
      c_s2    <= 1'b1;
      d_s1    <= 1'b1;
      d_s2    <= 1'b1;
      c_filt  <= 1'b1;
      c_prev  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      c_s1   <= ps2c_in;
      c_s2   <= c_s1;
      d_s1   <= ps2d_in;
      d_s2   <= d_s1;
      c_prev <= c_filt;
      // a new clock level is accepted only after FILTER_LEN agreeing samples
      if (c_s2 == c_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        c_filt  <= c_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall     = c_prev & ~c_filt;
  assign done_now = (state == S_WAIT_IDLE) && c_filt && d_s2;
  assign busy     = !((state == S_IDLE) || (state == S_ERR) || done_now);
  assign accept   = host.tx_start && !busy;
  assign timeout  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      sh       <= '0;
      edge_cnt <= '0;
      d_drive  <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept)
        inh_cnt <= '0;
      else if (state == S_INHIBIT)
        inh_cnt <= inh_cnt + IW'(1);

      // zero throughout INHIBIT, so START always begins with a fresh count
      if (state inside {S_START, S_DATA, S_PAR, S_ACK, S_WAIT_IDLE})
        tmo_cnt <= fall ? '0 : tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      if (accept) begin
        sh       <= {1'b1, ~^host.tx_data, host.tx_data};
        edge_cnt <= '0;
        d_drive  <= 1'b0;
      end else if (fall && (state inside {S_START, S_DATA, S_PAR, S_ACK})) begin
        edge_cnt <= edge_cnt + 4'd1;
        if (state != S_ACK) begin
          d_drive <= ~sh[0];
          sh      <= {1'b1, sh[9:1]};
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    ps2c_oe  = 1'b0;
    ps2d_oe  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2c_oe = 1'b1;
        ps2d_oe = inh_last;
        if (inh_last) state_nx = S_START;
      end
      S_START: begin
        ps2d_oe = 1'b1;
        if (timeout)   state_nx = S_ERR;
        else if (fall) state_nx = S_DATA;
      end
      S_DATA: begin
        ps2d_oe = d_drive;
        if (timeout)                          state_nx = S_ERR;
        else if (fall && edge_cnt == 4'd7)    state_nx = S_PAR;
      end
      S_PAR: begin
        ps2d_oe = d_drive;
        if (timeout)                          state_nx = S_ERR;
        else if (fall && edge_cnt == 4'd9)    state_nx = S_ACK;
      end
      S_ACK: begin
        if (timeout)   state_nx = S_ERR;
        else if (fall) state_nx = d_s2 ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (done_now)     state_nx = accept ? S_INHIBIT : S_IDLE;
        else if (timeout) state_nx = S_ERR;
      end
      S_ERR: begin
        state_nx = accept ? S_INHIBIT : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign host.busy       = busy;
  assign host.rx_inhibit = busy;
  assign host.tx_done    = done_now;
  assign host.tx_err     = (state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH = 300;
  localparam int TMO = 1500;
  localparam int FLT = 8;
  localparam int HP  = 30;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  logic ps2c_oe, ps2d_oe;
  logic ps2c_line, ps2d_line;
  assign ps2c_line = ~(ps2c_oe | dev_c_low);
  assign ps2d_line = ~(ps2d_oe | dev_d_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .host    (bus),
    .ps2c_in (ps2c_line),
    .ps2d_in (ps2d_line),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  int checks = 0;
  int errors = 0;

  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, rxi_bad = 0;
  int   inh_run = 0, inh_len = 0, hi_change = 0, dev_falls = 0;
  logic prev_d_oe = 1'b0;

  always @(negedge clock) begin
    if (bus.tx_done === 1'b1) done_cnt++;
    if (bus.tx_err === 1'b1) err_cnt++;
    if (bus.tx_done === 1'b1 && bus.tx_err === 1'b1) both_cnt++;
    if (bus.rx_inhibit !== bus.busy) rxi_bad++;
    if (ps2c_oe === 1'b1) inh_run++;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
    if (ps2d_oe !== prev_d_oe && ps2c_line === 1'b1) hi_change++;
    prev_d_oe = ps2d_oe;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Bits a device should observe after each of the first ten clocks: data LSB first, odd parity, stop
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] b);
    tick(1);
    bus.tx_start = 1'b1;
    bus.tx_data  = b;
    tick(1);
    bus.tx_start = 1'b0;
  endtask

  task automatic device_frame(input bit do_ack, output logic [9:0] seen, output bit ok);
    ok   = 1'b0;
    seen = '0;
    for (int i = 0; i < INH + 200; i++) begin
      @(negedge clock);
      if (ps2c_line === 1'b1 && ps2d_line === 1'b0 && bus.busy === 1'b1 && ps2c_oe === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      tick(40);
      for (int i = 0; i < 11; i++) begin
        if (i == 10 && do_ack) dev_d_low = 1'b1;
        dev_c_low = 1'b1;
        dev_falls++;
        tick(HP);
        if (i < 10) seen[i] = ps2d_line;
        dev_c_low = 1'b0;
        tick(HP);
        dev_d_low = 1'b0;
      end
    end
  endtask

  task automatic wait_settle(input int d0, input int e0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done_cnt != d0 || err_cnt != e0) break;
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack);
    int d0, e0, h0;
    logic [9:0] seen;
    bit ok;
    d0 = done_cnt; e0 = err_cnt; h0 = hi_change;
    pulse_start(b);
    device_frame(ack, seen, ok);
    wait_settle(d0, e0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_request byte=%02h: device saw no request-to-send", b);
    end
    checks++;
    if (seen !== model_frame(b)) begin
      errors++;
      $display("FAIL frame_bits byte=%02h: got %b required %b", b, seen, model_frame(b));
    end
    checks++;
    if (inh_len !== INH) begin
      errors++;
      $display("FAIL inhibit_len byte=%02h: got %0d required %0d", b, inh_len, INH);
    end
    checks++;
    if ((done_cnt - d0) !== (ack ? 1 : 0) || (err_cnt - e0) !== (ack ? 0 : 1)) begin
      errors++;
      $display("FAIL outcome byte=%02h ack=%0d: done=%0d err=%0d required done=%0d err=%0d",
               b, ack, done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
    end
    checks++;
    if ({bus.busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after byte=%02h: busy,c_oe,d_oe=%b required 000", b, {bus.busy, ps2c_oe, ps2d_oe});
    end
    if (ack) begin
      checks++;
      if (hi_change != h0) begin
        errors++;
        $display("FAIL data_while_clk_high byte=%02h: %0d changes required 0", b, hi_change - h0);
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    tick(5);
    @(negedge clock);
    checks++;
    if ({ps2c_oe, ps2d_oe, bus.busy, bus.rx_inhibit, bus.tx_done, bus.tx_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {ps2c_oe, ps2d_oe, bus.busy, bus.rx_inhibit, bus.tx_done, bus.tx_err});
    end
    tick(1);
    resetn = 1'b1;
    tick(20);
  endtask

  task automatic test_basic;
    run_frame(8'hED, 1'b1);
  endtask

  task automatic test_parity;
    run_frame(8'h07, 1'b1);
    run_frame(8'h00, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) run_frame(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic test_no_ack;
    run_frame(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_timeout;
    int e0, k;
    bit seen_inh, seen_start;
    e0 = err_cnt; k = -1; seen_inh = 0; seen_start = 0;
    pulse_start(8'hF4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ps2c_oe === 1'b1) begin seen_inh = 1; break; end
    end
    if (seen_inh) begin
      for (int i = 0; i < INH + 20; i++) begin
        @(negedge clock);
        if (ps2c_oe === 1'b0) begin seen_start = 1; break; end
      end
    end
    if (seen_start) begin
      for (int i = 1; i <= 2 * TMO; i++) begin
        @(negedge clock);
        if (bus.tx_err === 1'b1) begin k = i; break; end
      end
    end
    checks++;
    if (k !== TMO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles required %0d", k, TMO);
    end
    repeat (3) @(negedge clock);
    checks++;
    if ((err_cnt - e0) !== 1 || {bus.busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_release: err=%0d busy,c_oe,d_oe=%b required 1 and 000",
               err_cnt - e0, {bus.busy, ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] seen, seen2;
    logic [7:0] b1;
    bit ok, ok2, found;
    int d0, e0;
    logic busy_after;
    b1 = 8'($urandom_range(0, 255));
    found = 0; busy_after = 1'b0;
    pulse_start(8'hED);
    fork
      device_frame(1'b1, seen, ok);
      begin
        tick(INH + 200);
        pulse_start(8'hFF);
        for (int i = 0; i < 3000; i++) begin
          @(negedge clock);
          if (bus.tx_done === 1'b1) begin found = 1; break; end
        end
        if (found) begin
          pulse_start(b1);
          @(negedge clock);
          busy_after = bus.busy;
        end
      end
    join
    checks++;
    if (!ok || seen !== model_frame(8'hED)) begin
      errors++;
      $display("FAIL b2b_first_frame: got %b required %b", seen, model_frame(8'hED));
    end
    checks++;
    if (!found || busy_after !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_after_done: done_seen=%0d busy=%b required 1 and 1", found, busy_after);
    end
    d0 = done_cnt; e0 = err_cnt;
    device_frame(1'b1, seen2, ok2);
    wait_settle(d0, e0);
    checks++;
    if (!ok2 || seen2 !== model_frame(b1) || (done_cnt - d0) !== 1) begin
      errors++;
      $display("FAIL b2b_second_frame: got %b done=%0d required %b done=1", seen2, done_cnt - d0, model_frame(b1));
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] seen;
    bit ok, hit;
    int f0, d0, e0;
    logic [2:0] at_reset;
    f0 = dev_falls; d0 = done_cnt; e0 = err_cnt; hit = 0; at_reset = 3'bxxx;
    pulse_start(8'($urandom_range(0, 255)));
    fork
      device_frame(1'b1, seen, ok);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clock);
          if (dev_falls >= f0 + 5) begin hit = 1; break; end
        end
        tick(15);
        resetn = 1'b0;
        #1;
        at_reset = {ps2c_oe, ps2d_oe, bus.busy};
      end
    join
    checks++;
    if (!hit || at_reset !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_outputs: reached=%0d c_oe,d_oe,busy=%b required 000", hit, at_reset);
    end
    repeat (20) @(negedge clock);
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: done=%0d err=%0d required 0 and 0", done_cnt - d0, err_cnt - e0);
    end
    tick(1);
    resetn = 1'b1;
    tick(20);
    run_frame(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic test_monitors;
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL done_err_overlap: %0d cycles required 0", both_cnt);
    end
    checks++;
    if (rxi_bad !== 0) begin
      errors++;
      $display("FAIL rx_inhibit_eq_busy: %0d cycles differ required 0", rxi_bad);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_random;
    test_no_ack;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_monitors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
